// File: rtl/spi_arbiter_pkg.sv
// Shared types and defaults for the SPI engine arbiter.
//   arb_state_e : 2-bit arbiter state encoding (IDLE, LAUNCH, WAIT, DONE)
//   DEF_N_REQ   : default number of requesters
//   DEF_DATA_W  : default transfer word width
package spi_arb_pkg;

    localparam int unsigned DEF_N_REQ  = 2;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector, one bit per requester
//   rr_ptr_i : index of the last served requester; scanning starts just after it
//   grant_o  : one-hot winner (all zero when no request)
//   valid_o  : high when any request is set
module rr_pick #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     valid_o
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    int unsigned      scan;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk ptr+1, ptr+2, ... with wrap-around; the first set bit wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        scan    = 0;
        idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            scan = (32'(rr_ptr_i) + i) % N_REQ;
            idx  = PTR_W'(scan);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI transfer engine between N_REQ requesters.
// One transfer at a time: pick a requester, pulse go_transfer, wait for the
// engine's busy flag to fall, return the read word with a one-cycle done pulse.
//   clk, reset          : clock and synchronous active-high reset
//   req_go              : level request per requester (sampled only in IDLE)
//   req_wdata           : write word per requester, slice i at [i*DATA_W +: DATA_W]
//   req_grant           : one-hot owner of the current transfer
//   req_done / req_err  : one-cycle completion / timeout pulse to the owner
//   req_rdata           : last word read, shared by all requesters
//   busy                : high whenever the arbiter is not IDLE
//   go_transfer         : one-cycle start pulse to the engine
//   data_write_to_spi   : latched write word to the engine
//   data_pack_ready     : engine busy flag, falling edge marks completion
//   data_read_from_spi  : engine read word, valid at that falling edge
// Optional build macro SPI_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC
// cycles; without it WAIT is unbounded and req_err stays 0.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = DEF_N_REQ,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_go,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_grant,
    output logic [N_REQ-1:0]          req_done,
    output logic [N_REQ-1:0]          req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      busy,
    output logic                      go_transfer,
    output logic [DATA_W-1:0]         data_write_to_spi,
    input  logic                      data_pack_ready,
    input  logic [DATA_W-1:0]         data_read_from_spi
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              go_q, go_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              seen_busy_q, seen_busy_d;
    logic              ready_dly_q, ready_dly_d;

    logic [N_REQ-1:0]  pick_grant;
    logic              pick_valid;
    logic [PTR_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_wdata;
    logic              complete;
    logic              timeout;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i    (req_go),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_grant),
        .valid_o  (pick_valid)
    );

    // Encode the one-hot winner and select its write word.
    always_comb begin
        win_idx   = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                win_idx   = PTR_W'(i);
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // A low flag before the engine ever rose is not a completion; only a
    // genuine 1 -> 0 transition after seeing busy counts.
    assign complete = seen_busy_q & ready_dly_q & ~data_pack_ready;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] err_q, err_d;

    // Fires on the TIMEOUT_CYC-th WAIT cycle (counter starts at 0 in the first).
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = '0;
        if (state_q == LAUNCH) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (!complete && timeout) begin
                err_d = grant_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign req_err = err_q;
`else
    assign timeout = 1'b0;
    assign req_err = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        done_d      = '0;
        go_d        = 1'b0;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        seen_busy_d = seen_busy_q;
        ready_dly_d = ready_dly_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    owner_d = win_idx;
                    wdata_d = win_wdata;
                    go_d    = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                seen_busy_d = 1'b0;
                ready_dly_d = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                ready_dly_d = data_pack_ready;
                if (data_pack_ready) begin
                    seen_busy_d = 1'b1;
                end
                if (complete) begin
                    rdata_d = data_read_from_spi;
                    done_d  = grant_q;
                    state_d = DONE;
                end else if (timeout) begin
                    done_d  = grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = owner_q;
                grant_d  = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PTR_W'(N_REQ - 1);
            owner_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            go_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            seen_busy_q <= 1'b0;
            ready_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            go_q        <= go_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            seen_busy_q <= seen_busy_d;
            ready_dly_q <= ready_dly_d;
        end
    end

    assign req_grant         = grant_q;
    assign req_done          = done_q;
    assign req_rdata         = rdata_q;
    assign busy              = (state_q != IDLE);
    assign go_transfer       = go_q;
    assign data_write_to_spi = wdata_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (N_REQ=2, DATA_W=32, TIMEOUT_CYC=20).
// The engine is modelled by driving data_pack_ready / data_read_from_spi directly.
module tb_spi_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_go;
    logic [63:0] req_wdata;
    logic [1:0]  req_grant;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [31:0] req_rdata;
    logic        busy;
    logic        go_transfer;
    logic [31:0] data_write_to_spi;
    logic        data_pack_ready;
    logic [31:0] data_read_from_spi;

    int n_cmp;
    int n_err;
    int go_cnt;

    spi_arbiter #(
        .N_REQ       (2),
        .DATA_W      (32),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_go             (req_go),
        .req_wdata          (req_wdata),
        .req_grant          (req_grant),
        .req_done           (req_done),
        .req_err            (req_err),
        .req_rdata          (req_rdata),
        .busy               (busy),
        .go_transfer        (go_transfer),
        .data_write_to_spi  (data_write_to_spi),
        .data_pack_ready    (data_pack_ready),
        .data_read_from_spi (data_read_from_spi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts start pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (go_transfer) go_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full transfer from IDLE. req_go must already be set by the caller.
    task automatic run_xfer(input string tag, input logic [1:0] go_after, input logic [63:0] wd,
                            input logic [1:0] exp_g, input logic [31:0] exp_wd,
                            input int pre, input int blen, input logic [31:0] rd);
        logic [1:0] early;
        early     = '0;
        req_wdata = wd;
        step(1);
        check({tag, "/grant"}, 64'(req_grant), 64'(exp_g));
        check({tag, "/go_hi"}, 64'(go_transfer), 64'd1);
        check({tag, "/wdata"}, 64'(data_write_to_spi), 64'(exp_wd));
        req_go    = go_after;
        req_wdata = ~wd;
        step(1);
        check({tag, "/go_lo"}, 64'(go_transfer), 64'd0);
        repeat (pre) begin
            step(1);
            early |= req_done;
        end
        data_pack_ready = 1'b1;
        repeat (blen) begin
            step(1);
            early |= req_done;
        end
        data_pack_ready    = 1'b0;
        data_read_from_spi = rd;
        step(1);
        check({tag, "/no_early"}, 64'(early), 64'd0);
        check({tag, "/done"}, 64'(req_done), 64'(exp_g));
        check({tag, "/err"}, 64'(req_err), 64'd0);
        check({tag, "/rdata"}, 64'(req_rdata), 64'(rd));
        check({tag, "/wdata_held"}, 64'(data_write_to_spi), 64'(exp_wd));
        step(1);
        check({tag, "/done_pulse"}, 64'(req_done), 64'd0);
        check({tag, "/grant_clr"}, 64'(req_grant), 64'd0);
        check({tag, "/idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0] seen;
        int         go_base;
        n_cmp              = 0;
        n_err              = 0;
        go_cnt             = 0;
        reset              = 1'b1;
        req_go             = '0;
        req_wdata          = '0;
        data_pack_ready    = 1'b0;
        data_read_from_spi = '0;
        step(2);
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/grant", 64'(req_grant), 64'd0);
        check("rst/go", 64'(go_transfer), 64'd0);
        check("rst/done", 64'(req_done), 64'd0);
        check("rst/err", 64'(req_err), 64'd0);
        check("rst/rdata", 64'(req_rdata), 64'd0);
        check("rst/wdata", 64'(data_write_to_spi), 64'd0);
        reset = 1'b0;
        step(1);

        // Single request from requester 0.
        req_go = 2'b01;
        run_xfer("single", 2'b00, {32'h0, 32'hA5A5A5A5}, 2'b01, 32'hA5A5A5A5, 0, 10, 32'h12345678);
        step(2);
        check("idle_hold/go", 64'(go_transfer), 64'd0);
        check("idle_hold/busy", 64'(busy), 64'd0);

        // Contention from a fresh reset: strict alternation.
        reset = 1'b1;
        step(1);
        reset   = 1'b0;
        go_base = go_cnt;
        req_go  = 2'b11;
        run_xfer("cont0", 2'b11, {32'hBBBB0001, 32'hCCCC0000}, 2'b01, 32'hCCCC0000, 0, 3, 32'h00000A01);
        run_xfer("cont1", 2'b11, {32'hBBBB0001, 32'hCCCC0000}, 2'b10, 32'hBBBB0001, 0, 3, 32'h00000A02);
        run_xfer("cont2", 2'b11, {32'hBBBB0001, 32'hCCCC0000}, 2'b01, 32'hCCCC0000, 0, 3, 32'h00000A03);
        run_xfer("cont3", 2'b00, {32'hBBBB0001, 32'hCCCC0000}, 2'b10, 32'hBBBB0001, 0, 3, 32'h00000A04);
        check("cont/go_count", 64'(go_cnt - go_base), 64'd4);

        // Late engine start: low 3 cycles, high 5, then falls.
        req_go = 2'b01;
        run_xfer("late", 2'b00, {32'h0, 32'h0F0F0F0F}, 2'b01, 32'h0F0F0F0F, 3, 5, 32'hDEADBEEF);

        // Reset while waiting on the engine; rr_ptr is now 0 so requester 1 wins.
        req_go    = 2'b10;
        req_wdata = {32'h11112222, 32'h0};
        step(1);
        check("rstw/grant", 64'(req_grant), 64'h2);
        req_go = 2'b00;
        step(1);
        data_pack_ready    = 1'b1;
        data_read_from_spi = 32'hFFFF0000;
        step(3);
        reset = 1'b1;
        step(1);
        check("rstw/busy", 64'(busy), 64'd0);
        check("rstw/grant0", 64'(req_grant), 64'd0);
        check("rstw/go", 64'(go_transfer), 64'd0);
        check("rstw/rdata", 64'(req_rdata), 64'd0);
        check("rstw/wdata", 64'(data_write_to_spi), 64'd0);
        reset           = 1'b0;
        data_pack_ready = 1'b0;
        step(1);
        req_go = 2'b11;
        run_xfer("after_rst", 2'b00, {32'h22220002, 32'h33330003}, 2'b01, 32'h33330003, 0, 2,
                 32'h600DCAFE);

        // Engine stuck busy.
        req_go = 2'b01;
        step(1);
        check("stuck/grant", 64'(req_grant), 64'h1);
        req_go = 2'b00;
        step(1);
        data_pack_ready = 1'b1;
        seen            = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (19) begin
            step(1);
            seen |= req_done | req_err;
        end
        check("tmo/no_early", 64'(seen), 64'd0);
        step(1);
        check("tmo/done", 64'(req_done), 64'h1);
        check("tmo/err", 64'(req_err), 64'h1);
        check("tmo/rdata_kept", 64'(req_rdata), 64'h600DCAFE);
        step(1);
        check("tmo/err_pulse", 64'(req_err), 64'd0);
        check("tmo/idle", 64'(busy), 64'd0);
`else
        repeat (40) begin
            step(1);
            seen |= req_done | req_err;
        end
        check("notmo/no_done", 64'(seen), 64'd0);
        check("notmo/busy", 64'(busy), 64'd1);
        check("notmo/rdata_kept", 64'(req_rdata), 64'h600DCAFE);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
`endif
        data_pack_ready = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
